sr_flag_arbiter: RTL and testbench

- Shares a bank of NFLAG external SR flip-flops (inputs S, R, clk; output Q) among NREQ requesters.
- Each requester issues set, clear or toggle commands to one flag index through a valid/ready handshake.
- A round-robin arbiter grants one command per cycle and emits registered one-cycle S/R pulses. S and R are never both high, so the illegal 2'b11 case of the flops is never reached.
- Keeps a shadow copy of the flag states so toggle can be resolved and status can be reported.

---
 rtl/sr_flag_arbiter_if.sv | 24 ++
 rtl/sr_flag_arbiter.sv | 113 +++++++++++
 tb/tb_sr_flag_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/sr_flag_arbiter_if.sv
// rtl/sr_flag_arbiter_if.sv - requester command bundle for the SR flag arbiter
interface sr_flag_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_op;
    logic [IDXW*NREQ-1:0] req_idx;
    logic [NREQ-1:0]      req_ready;

    modport master (
        output req_valid,
        output req_op,
        output req_idx,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_idx,
        output req_ready
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin arbiter driving a bank of external SR flops
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3,
    parameter bit INIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    sr_flag_arbiter_if.slave  req,
    input  logic              clr_all,
    input  logic              pause,
    output logic [NFLAG-1:0]  s_out,
    output logic [NFLAG-1:0]  r_out,
    output logic [NFLAG-1:0]  flag_q,
    output logic              err,
    output logic [2:0]        grant_id
);

    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [NREQ-1:0]  gnt_raw;
    logic [2:0]       gidx;
    logic             found;
    logic             accept;
    logic [1:0]       sel_op;
    logic [IDXW-1:0]  sel_idx;
    logic [NFLAG-1:0] onehot;
    logic             cur;
    logic             illegal;
    logic             do_set;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        int j;
        j       = 0;
        gnt_raw = '0;
        gidx    = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req.req_valid[j]) begin
                found      = 1'b1;
                gnt_raw[j] = 1'b1;
                gidx       = 3'(j);
            end
        end
    end

    // Grants are suppressed during reset, pause and broadcast clear.
    assign req.req_ready = (rst || pause || clr_all) ? '0 : gnt_raw;
    assign accept        = found && !pause && !clr_all;
    assign ptr_nxt       = (gidx == 3'(NREQ - 1)) ? 3'd0 : gidx + 3'd1;

    // Select the winning command and decode it against the shadow state.
    always_comb begin
        sel_op  = 2'b00;
        sel_idx = '0;
        onehot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_raw[i]) begin
                sel_op  = req.req_op[2*i +: 2];
                sel_idx = req.req_idx[IDXW*i +: IDXW];
            end
        end
        // An index with no matching flag leaves onehot empty and is rejected.
        for (int f = 0; f < NFLAG; f++) begin
            if (sel_idx == IDXW'(f)) begin
                onehot[f] = 1'b1;
            end
        end
    end

    assign cur     = |(flag_q & onehot);
    assign illegal = (sel_op == 2'b00) || (onehot == '0);
    assign do_set  = (sel_op == 2'b10) || ((sel_op == 2'b11) && !cur);

    // Pulse generation, shadow update and pointer advance; pulses last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= 3'd0;
            flag_q   <= {NFLAG{INIT}};
            s_out    <= '0;
            r_out    <= '0;
            err      <= 1'b0;
            grant_id <= 3'd0;
        end else begin
            s_out <= '0;
            r_out <= '0;
            err   <= 1'b0;
            if (clr_all) begin
                flag_q <= '0;
                r_out  <= '1;
            end else if (accept) begin
                ptr      <= ptr_nxt;
                grant_id <= gidx;
                if (illegal) begin
                    err <= 1'b1;
                end else if (do_set) begin
                    flag_q <= flag_q | onehot;
                    s_out  <= onehot;
                end else begin
                    flag_q <= flag_q & ~onehot;
                    r_out  <= onehot;
                end
            end
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - directed self-checking bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_all = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] s_out, r_out, flag_q;
    logic       err;
    logic [2:0] grant_id;
    logic [5:0] s_out2, r_out2, flag_q2;
    logic       err2;
    logic [2:0] grant_id2;

    int tests = 0;
    int fails = 0;

    sr_flag_arbiter_if #(.NREQ(4), .IDXW(3)) bus ();
    sr_flag_arbiter_if #(.NREQ(4), .IDXW(3)) bus2 ();

    sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3), .INIT(1'b0)) dut (
        .clk(clk), .rst(rst), .req(bus.slave), .clr_all(clr_all), .pause(pause),
        .s_out(s_out), .r_out(r_out), .flag_q(flag_q), .err(err), .grant_id(grant_id)
    );

    sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3), .INIT(1'b0)) dut2 (
        .clk(clk), .rst(rst), .req(bus2.slave), .clr_all(1'b0), .pause(1'b0),
        .s_out(s_out2), .r_out(r_out2), .flag_q(flag_q2), .err(err2), .grant_id(grant_id2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req_valid  = 4'b1111;
        bus.req_op     = 8'b0;
        bus.req_idx    = 12'b0;
        bus2.req_valid = 4'b0;
        bus2.req_op    = 8'b0;
        bus2.req_idx   = 12'b0;

        // Reset state
        #1;
        chk("rst_ready", bus.req_ready, 4'b0000);
        tick();
        chk("rst_flag", flag_q, 8'h00);
        chk("rst_s", s_out, 8'h00);
        chk("rst_r", r_out, 8'h00);
        chk("rst_err", err, 1'b0);
        chk("rst_gid", grant_id, 3'd0);
        chk("rst_flag2", flag_q2, 6'h00);
        bus.req_valid = 4'b0000;
        rst = 1'b0;

        // Pause blocks grants
        bus.req_valid = 4'b0001;
        bus.req_op    = 8'b00_00_00_10;
        bus.req_idx   = {3'd0, 3'd0, 3'd0, 3'd5};
        pause = 1'b1;
        #1;
        chk("pause_ready", bus.req_ready, 4'b0000);
        pause = 1'b0;
        #1;
        chk("t1_ready", bus.req_ready, 4'b0001);
        tick();
        chk("t1_s", s_out, 8'h20);
        chk("t1_r", r_out, 8'h00);
        chk("t1_flag", flag_q, 8'h20);
        chk("t1_gid", grant_id, 3'd0);
        bus.req_valid = 4'b0000;
        tick();
        chk("t1_s_end", s_out, 8'h00);
        chk("t1_flag_hold", flag_q, 8'h20);

        // Async reset pulse between edges restores a clean start
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        chk("rst2_flag", flag_q, 8'h00);

        // Round robin across all four, two rounds to fill all eight flags
        bus.req_valid = 4'b1111;
        bus.req_op    = 8'b10_10_10_10;
        bus.req_idx   = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", bus.req_ready, 32'(1 << k));
            tick();
            chk("rr_s", s_out, 32'(1 << k));
            chk("rr_sr_excl", s_out & r_out, 8'h00);
            chk("rr_gid", grant_id, 32'(k));
        end
        chk("rr_flag", flag_q, 8'h0F);
        bus.req_idx = {3'd7, 3'd6, 3'd5, 3'd4};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr2_s", s_out, 32'(16 << k));
        end
        chk("rr2_flag", flag_q, 8'hFF);

        // Broadcast clear wins over a pending request; ptr stays at 0
        bus.req_valid = 4'b0101;
        bus.req_op    = 8'b00_10_00_10;
        bus.req_idx   = {3'd0, 3'd3, 3'd0, 3'd0};
        clr_all = 1'b1;
        #1;
        chk("clr_ready", bus.req_ready, 4'b0000);
        tick();
        chk("clr_r", r_out, 8'hFF);
        chk("clr_s", s_out, 8'h00);
        chk("clr_flag", flag_q, 8'h00);
        chk("clr_gid", grant_id, 3'd3);
        clr_all = 1'b0;
        #1;
        chk("post_clr_ready", bus.req_ready, 4'b0001);
        tick();
        chk("post_clr_r", r_out, 8'h00);
        chk("post_clr_s", s_out, 8'h01);
        chk("post_clr_flag", flag_q, 8'h01);

        // Toggle twice from req1 on idx 2
        bus.req_valid = 4'b0010;
        bus.req_op    = 8'b00_00_11_00;
        bus.req_idx   = {3'd0, 3'd0, 3'd2, 3'd0};
        #1;
        chk("tog_ready", bus.req_ready, 4'b0010);
        tick();
        chk("tog1_s", s_out, 8'h04);
        chk("tog1_r", r_out, 8'h00);
        chk("tog1_flag", flag_q, 8'h05);
        tick();
        chk("tog2_s", s_out, 8'h00);
        chk("tog2_r", r_out, 8'h04);
        chk("tog2_flag", flag_q, 8'h01);
        bus.req_valid = 4'b0000;
        tick();
        chk("tog_end_r", r_out, 8'h00);

        // Illegal op and out-of-range index on the six-flag instance
        bus2.req_valid = 4'b0100;
        bus2.req_op    = 8'b00_00_00_00;
        bus2.req_idx   = {3'd0, 3'd1, 3'd0, 3'd0};
        #1;
        chk("ill_ready", bus2.req_ready, 4'b0100);
        tick();
        chk("ill_err", err2, 1'b1);
        chk("ill_flag", flag_q2, 6'h00);
        chk("ill_sr", {s_out2, r_out2}, 12'h000);
        chk("ill_gid", grant_id2, 3'd2);
        bus2.req_op  = 8'b00_10_00_00;
        bus2.req_idx = {3'd0, 3'd7, 3'd0, 3'd0};
        #1;
        chk("oor_ready", bus2.req_ready, 4'b0100);
        tick();
        chk("oor_err", err2, 1'b1);
        chk("oor_flag", flag_q2, 6'h00);
        chk("oor_sr", {s_out2, r_out2}, 12'h000);
        bus2.req_valid = 4'b0000;
        tick();
        chk("err_end", err2, 1'b0);
        chk("main_err", err, 1'b0);

        // Reset mid-cycle while a set pulse is in flight
        bus.req_valid = 4'b0001;
        bus.req_op    = 8'b00_00_00_10;
        bus.req_idx   = {3'd0, 3'd0, 3'd0, 3'd4};
        tick();
        chk("pre_rst_s", s_out, 8'h10);
        chk("pre_rst_flag", flag_q, 8'h11);
        bus.req_valid = 4'b0011;
        bus.req_op    = 8'b00_00_10_10;
        bus.req_idx   = {3'd0, 3'd0, 3'd1, 3'd4};
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_s", s_out, 8'h00);
        chk("mid_rst_r", r_out, 8'h00);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_ready", bus.req_ready, 4'b0000);
        chk("mid_rst_flag", flag_q, 8'h00);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.req_ready, 4'b0001);
        tick();
        chk("post_rst_s", s_out, 8'h10);
        chk("post_rst_gid", grant_id, 3'd0);
        bus.req_valid = 4'b0000;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
